// File: rtl/spi_mem_loader.sv
// spi_mem_loader: SPI-slave (mode 0) program loader for the instruction and data memories.
//
// A frame is a 16-bit header {W/Rn, I/Dn, rsvd, addr[12:8], addr[7:0]} followed by any
// number of 16-bit words. Write frames store each word at an auto-incrementing address.
// Read frames stream memory contents out on miso. The loader only acts while start = 0.
//
// Optional feature macro: SPI_LOADER_READBACK_EN (read frames). When it is undefined,
// read frames are swallowed by a sink state and miso is tied to 0.
//
// Ports:
//   clk, reset          system clock, asynchronous active-low reset
//   start               processor run flag; 1 forces idle and blocks strobes
//   sck, cs_n, mosi     SPI inputs, asynchronous to clk
//   miso                SPI data out, MSB first
//   instrw_en/dataw_en  one-cycle write strobes
//   instr_mem_addr      13-bit instruction memory address
//   data_mem_addr       8-bit data memory address
//   mem_write_data      shared write data
//   instr/data_read_data memory read data (RD_LAT cycles after address)
//   busy                frame in progress
module spi_mem_loader #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sck,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        instrw_en,
    output logic        dataw_en,
    output logic [12:0] instr_mem_addr,
    output logic [7:0]  data_mem_addr,
    output logic [15:0] mem_write_data,
    input  logic [15:0] instr,
    input  logic [15:0] data_read_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StWdata,
        StRfetch,
        StRdata,
        StSink
    } state_e;

    state_e state_q, state_d;

    // Two-flop synchronisers; cs_n resets to its inactive level.
    logic [1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic       sck_prev_q;
    logic       sck_s, cs_s, mosi_s, sck_rise;

    logic [15:0] shift_q, shift_d, shift_in;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        isel_q, isel_d;
    logic [12:0] instr_addr_q, instr_addr_d;
    logic [7:0]  data_addr_q, data_addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        instrw_q, instrw_d, dataw_q, dataw_d;

`ifdef SPI_LOADER_READBACK_EN
    logic [1:0] lat_cnt_q, lat_cnt_d;
    logic       sck_fall;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync_q  <= 2'b00;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sck_prev_q  <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], sck};
            cs_sync_q   <= {cs_sync_q[0], cs_n};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            sck_prev_q  <= sck_sync_q[1];
        end
    end

    assign sck_s    = sck_sync_q[1];
    assign cs_s     = cs_sync_q[1];
    assign mosi_s   = mosi_sync_q[1];
    assign sck_rise = sck_s & ~sck_prev_q;
`ifdef SPI_LOADER_READBACK_EN
    assign sck_fall = ~sck_s & sck_prev_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            shift_q      <= 16'h0000;
            bit_cnt_q    <= 4'd0;
            isel_q       <= 1'b0;
            instr_addr_q <= 13'h0000;
            data_addr_q  <= 8'h00;
            wdata_q      <= 16'h0000;
            instrw_q     <= 1'b0;
            dataw_q      <= 1'b0;
`ifdef SPI_LOADER_READBACK_EN
            lat_cnt_q    <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            isel_q       <= isel_d;
            instr_addr_q <= instr_addr_d;
            data_addr_q  <= data_addr_d;
            wdata_q      <= wdata_d;
            instrw_q     <= instrw_d;
            dataw_q      <= dataw_d;
`ifdef SPI_LOADER_READBACK_EN
            lat_cnt_q    <= lat_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        isel_d       = isel_q;
        instr_addr_d = instr_addr_q;
        data_addr_d  = data_addr_q;
        wdata_d      = wdata_q;
        instrw_d     = 1'b0;
        dataw_d      = 1'b0;
        shift_in     = {shift_q[14:0], mosi_s};
`ifdef SPI_LOADER_READBACK_EN
        lat_cnt_d    = lat_cnt_q;
`endif

        // Address advances in the cycle after a strobe that actually reached the memory,
        // independent of state so a strobe racing an abort still counts.
        if (instrw_q && !start) begin
            instr_addr_d = instr_addr_q + 13'd1;
        end
        if (dataw_q && !start) begin
            data_addr_d = data_addr_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (!cs_s && !start) begin
                    state_d   = StHdr;
                    bit_cnt_d = 4'd0;
                end
            end
            StHdr: begin
                if (sck_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        isel_d = shift_in[14];
                        // Only the selected memory's address is loaded; the other holds.
                        if (shift_in[14]) begin
                            instr_addr_d = shift_in[12:0];
                        end else begin
                            data_addr_d = shift_in[7:0];
                        end
                        if (shift_in[15]) begin
                            state_d = StWdata;
                        end else begin
`ifdef SPI_LOADER_READBACK_EN
                            state_d   = StRfetch;
                            lat_cnt_d = 2'd0;
`else
                            state_d = StSink;
`endif
                        end
                    end
                end
            end
            StWdata: begin
                if (sck_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        wdata_d  = shift_in;
                        instrw_d = isel_q & ~start;
                        dataw_d  = ~isel_q & ~start;
                    end
                end
            end
`ifdef SPI_LOADER_READBACK_EN
            StRfetch: begin
                // Address was presented on entry; data is valid RD_LAT cycles later.
                if (lat_cnt_q == RD_LAT[1:0]) begin
                    shift_d   = isel_q ? instr : data_read_data;
                    bit_cnt_d = 4'd0;
                    state_d   = StRdata;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            StRdata: begin
                // The fall that trails the previous word's last rise must not shift out
                // the freshly loaded MSB, so shifting starts after the first rise.
                if (sck_fall && bit_cnt_q != 4'd0) begin
                    shift_d = {shift_q[14:0], 1'b0};
                end
                if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        if (isel_q) begin
                            instr_addr_d = instr_addr_q + 13'd1;
                        end else begin
                            data_addr_d = data_addr_q + 8'd1;
                        end
                        state_d   = StRfetch;
                        lat_cnt_d = 2'd0;
                    end
                end
            end
`endif
            StSink: begin
                state_d = StSink;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Chip-select release or processor start aborts any frame.
        if (state_q != StIdle && (cs_s || start)) begin
            state_d = StIdle;
        end
    end

    assign instrw_en      = instrw_q & ~start;
    assign dataw_en       = dataw_q & ~start;
    assign instr_mem_addr = instr_addr_q;
    assign data_mem_addr  = data_addr_q;
    assign mem_write_data = wdata_q;
    assign busy           = (state_q != StIdle);

`ifdef SPI_LOADER_READBACK_EN
    assign miso = (state_q == StRdata) ? shift_q[15] : 1'b0;
`else
    logic unused_rd;
    assign unused_rd = ^{instr, data_read_data, RD_LAT[1:0]};
    assign miso      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_mem_loader.sv
// Self-checking bench for spi_mem_loader: a timed SPI master drives frames, a reference
// model predicts write strobes and read words into queues, and monitors compare them.
module tb_spi_mem_loader;

    localparam int unsigned RD_LAT = 2;
    localparam int HALF = 80;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sck = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, instrw_en, dataw_en, busy;
    logic [12:0] instr_mem_addr;
    logic [7:0]  data_mem_addr;
    logic [15:0] mem_write_data, instr, data_read_data;

    spi_mem_loader #(.RD_LAT(RD_LAT)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .sck            (sck),
        .cs_n           (cs_n),
        .mosi           (mosi),
        .miso           (miso),
        .instrw_en      (instrw_en),
        .dataw_en       (dataw_en),
        .instr_mem_addr (instr_mem_addr),
        .data_mem_addr  (data_mem_addr),
        .mem_write_data (mem_write_data),
        .instr          (instr),
        .data_read_data (data_read_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

`ifdef SPI_LOADER_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    // Memories seen by the DUT, with RD_LAT-cycle read pipeline.
    logic [15:0] imem [0:8191];
    logic [15:0] dmem [0:255];
    logic [15:0] i_p1, i_p2, d_p1, d_p2;
    always @(posedge clk) begin
        if (instrw_en) imem[instr_mem_addr] <= mem_write_data;
        if (dataw_en) dmem[data_mem_addr] <= mem_write_data;
        i_p1 <= imem[instr_mem_addr];
        i_p2 <= i_p1;
        d_p1 <= dmem[data_mem_addr];
        d_p2 <= d_p1;
    end
    assign instr          = (RD_LAT == 1) ? i_p1 : i_p2;
    assign data_read_data = (RD_LAT == 1) ? d_p1 : d_p2;

    // Reference model state.
    logic [15:0] ref_imem [0:8191];
    logic [15:0] ref_dmem [0:255];
    logic [12:0] m_iaddr = 13'h0;
    logic [7:0]  m_daddr = 8'h0;

    typedef struct packed {
        logic        isel;
        logic [12:0] addr;
        logic [12:0] oth;
        logic [15:0] data;
    } wr_t;

    wr_t         wr_q [$];
    logic [15:0] rd_q [$];
    logic [15:0] wbuf [$];
    wr_t         e;
    bit          start_chk = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " miso"}, {31'd0, miso}, 32'd0);
        check({tag, " instrw_en"}, {31'd0, instrw_en}, 32'd0);
        check({tag, " dataw_en"}, {31'd0, dataw_en}, 32'd0);
        check({tag, " instr_mem_addr"}, {19'd0, instr_mem_addr}, 32'd0);
        check({tag, " data_mem_addr"}, {24'd0, data_mem_addr}, 32'd0);
        check({tag, " mem_write_data"}, {16'd0, mem_write_data}, 32'd0);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
    endtask

    // SPI master, mode 0: mosi changes while sck is low, slave samples on rise.
    task automatic spi_bit(input logic b);
        mosi = b;
        #HALF sck = 1'b1;
        #HALF sck = 1'b0;
    endtask

    task automatic spi_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) spi_bit(w[i]);
    endtask

    // Edges land 3 ns after a clk posedge, away from the DUT sampling edge.
    task automatic frame_begin();
        @(posedge clk);
        #3;
        cs_n = 1'b0;
        #100;
    endtask

    task automatic frame_end();
        #100;
        cs_n = 1'b1;
        mosi = 1'b0;
        #300;
        check("miso idle after frame", {31'd0, miso}, 32'd0);
        check("busy idle after frame", {31'd0, busy}, 32'd0);
    endtask

    task automatic write_frame(input logic isel, input logic [12:0] a);
        wr_t x;
        if (!start) begin
            if (isel) m_iaddr = a;
            else m_daddr = a[7:0];
        end
        frame_begin();
        spi_word({1'b1, isel, 1'b0, a});
        foreach (wbuf[k]) begin
            if (!start) begin
                x.isel = isel;
                x.addr = isel ? m_iaddr : {5'd0, m_daddr};
                x.oth  = isel ? {5'd0, m_daddr} : m_iaddr;
                x.data = wbuf[k];
                wr_q.push_back(x);
                if (isel) begin
                    ref_imem[m_iaddr] = wbuf[k];
                    m_iaddr = m_iaddr + 13'd1;
                end else begin
                    ref_dmem[m_daddr] = wbuf[k];
                    m_daddr = m_daddr + 8'd1;
                end
            end
            spi_word(wbuf[k]);
        end
        frame_end();
        wbuf.delete();
    endtask

    task automatic read_frame(input logic isel, input logic [12:0] a, input int n);
        if (isel) m_iaddr = a;
        else m_daddr = a[7:0];
        frame_begin();
        spi_word({1'b0, isel, 1'b0, a});
        for (int k = 0; k < n; k++) begin
            if (READBACK) begin
                rd_q.push_back(isel ? ref_imem[m_iaddr] : ref_dmem[m_daddr]);
                if (isel) m_iaddr = m_iaddr + 13'd1;
                else m_daddr = m_daddr + 8'd1;
            end else begin
                rd_q.push_back(16'h0000);
            end
            spi_word(16'($urandom));
        end
        frame_end();
    endtask

    // Write-strobe monitor.
    always @(negedge clk) begin
        if (instrw_en || dataw_en) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected strobe: got instrw_en=%0b dataw_en=%0b expected none",
                         instrw_en, dataw_en);
            end else begin
                e = wr_q.pop_front();
                check("strobe select", {30'd0, instrw_en, dataw_en}, {30'd0, e.isel, ~e.isel});
                check("write data", {16'd0, mem_write_data}, {16'd0, e.data});
                if (e.isel) begin
                    check("instr addr", {19'd0, instr_mem_addr}, {19'd0, e.addr});
                    check("data addr held", {24'd0, data_mem_addr}, {19'd0, e.oth});
                end else begin
                    check("data addr", {24'd0, data_mem_addr}, {19'd0, e.addr});
                    check("instr addr held", {19'd0, instr_mem_addr}, {19'd0, e.oth});
                end
            end
        end
        if (start_chk) check("busy while start", {31'd0, busy}, 32'd0);
    end

    // miso monitor: decodes the header from mosi and checks each word of read frames.
    initial begin
        int          mbits;
        logic [15:0] mhdr, mword, exp_w;
        forever begin
            @(negedge cs_n);
            mbits = 0;
            mhdr  = 16'h0;
            mword = 16'h0;
            while (cs_n == 1'b0) begin
                @(posedge sck or posedge cs_n);
                if (!cs_n) begin
                    if (mbits < 16) begin
                        mhdr = {mhdr[14:0], mosi};
                    end else begin
                        mword = {mword[14:0], miso};
                        if (!mhdr[15] && (mbits % 16) == 15) begin
                            if (rd_q.size() == 0) begin
                                n_checks++;
                                n_fail++;
                                $display("FAIL unexpected read word: got %0h expected none",
                                         mword);
                            end else begin
                                exp_w = rd_q.pop_front();
                                check("miso word", {16'd0, mword}, {16'd0, exp_w});
                            end
                        end
                    end
                    mbits++;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 8192; i++) begin
            imem[i]     = 16'($urandom);
            ref_imem[i] = imem[i];
        end
        for (int i = 0; i < 256; i++) begin
            dmem[i]     = 16'($urandom);
            ref_dmem[i] = dmem[i];
        end

        #2 reset = 1'b0;
        #20;
        check_reset_vals("reset");
        reset = 1'b1;
        #50;

        // Instruction write burst.
        wbuf.push_back(16'h2004);
        wbuf.push_back(16'hABCD);
        write_frame(1'b1, 13'h0010);

        // Data address wrap; addr[12:8] set to prove they are ignored.
        wbuf.push_back(16'($urandom));
        wbuf.push_back(16'($urandom));
        write_frame(1'b0, 13'h15FF);

        // Readback of known contents.
        wbuf.push_back(16'h1234);
        wbuf.push_back(16'h5678);
        write_frame(1'b1, 13'h0005);
        read_frame(1'b1, 13'h0005, 2);

        // Abort after 9 data bits: no strobe, selected address still loaded.
        m_daddr = 8'h42;
        frame_begin();
        spi_word({1'b1, 1'b0, 1'b0, 13'h0042});
        for (int i = 0; i < 9; i++) spi_bit(1'b1);
        frame_end();
        wbuf.push_back(16'h0F0F);
        write_frame(1'b0, 13'h0043);

        // Start gating: no strobes, busy stays 0.
        start = 1'b1;
        #50;
        start_chk = 1'b1;
        wbuf.push_back(16'hDEAD);
        wbuf.push_back(16'hBEEF);
        write_frame(1'b1, 13'h0100);
        start_chk = 1'b0;
        start = 1'b0;
        #100;

        // Randomised frames.
        for (int it = 0; it < 8; it++) begin
            logic        isel, rd;
            logic [12:0] a;
            int          n;
            isel = 1'($urandom);
            rd   = 1'($urandom);
            a    = 13'($urandom);
            n    = int'($urandom_range(1, 3));
            if (rd) begin
                read_frame(isel, a, n);
            end else begin
                for (int k = 0; k < n; k++) wbuf.push_back(16'($urandom));
                write_frame(isel, a);
            end
        end

        // Asynchronous reset mid-WDATA.
        frame_begin();
        spi_word({1'b1, 1'b1, 1'b0, 13'h0123});
        for (int i = 0; i < 5; i++) spi_bit(1'b1);
        reset = 1'b0;
        #1;
        check_reset_vals("mid-frame reset");
        cs_n = 1'b1;
        #50;
        reset = 1'b1;
        m_iaddr = 13'h0;
        m_daddr = 8'h0;
        #200;

        // Post-reset frame still works.
        wbuf.push_back(16'h55AA);
        write_frame(1'b0, 13'h0007);

        #200;
        check("pending strobes", wr_q.size(), 32'd0);
        check("pending read words", rd_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case stimulus ever stalls.
    initial begin
        #5ms;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_mem_loader.md
# spi_mem_loader

SPI-slave program loader that fills the processor's instruction and data memories from an external host over four pins, as a serial alternative to the 16-bit parallel load path. It sits directly upstream of the memory-side ports of the I/O interface stage. It drives write strobes, addresses and write data into the same instruction (13-bit address) and data (8-bit address) memories, and supports optional readback. It is active only while the processor is held idle (`start` = 0).

## Interface
Parameters:
- `RD_LAT`, default 1: memory read latency in `clk` cycles, from address presented to read data valid. Legal values are 1 or 2.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  processor run flag; when 1 the loader is disabled.
- `sck`  in  1  SPI clock, mode 0; asynchronous to `clk`.
- `cs_n`  in  1  SPI chip select, active low; asynchronous.
- `mosi`  in  1  SPI data in, MSB first; asynchronous.
- `miso`  out  1  SPI data out, MSB first.
- `instrw_en`  out  1  instruction memory write strobe, one cycle.
- `dataw_en`  out  1  data memory write strobe, one cycle.
- `instr_mem_addr`  out  13  instruction memory address.
- `data_mem_addr`  out  8  data memory address.
- `mem_write_data`  out  16  write data, shared by both memories.
- `instr`  in  16  instruction memory read data.
- `data_read_data`  in  16  data memory read data.
- `busy`  out  1  high while a frame is in progress (any state other than IDLE).

## Operation
- Input synchronisation: `sck`, `cs_n` and `mosi` each pass through a 2-flop synchroniser into the `clk` domain. Rising and falling edges of `sck` are detected on the synchronised signal.
- Frame format:
  - Bits 0–15 form the header: cmd[7] is W/R̄ (1 = write), cmd[6] is I/D̄ (1 = instruction memory), cmd[5] is reserved, cmd[4:0] is addr[12:8], and byte 2 is addr[7:0].
  - The header is followed by any number of 16-bit words.
- Address use: a data-memory frame uses addr[7:0] only; addr[12:8] are ignored.
- State machine:
  - **IDLE**: `cs_n` low and `start` = 0 → HDR.
  - **HDR**: shift `mosi` on each `sck` rise. After the 16th bit, latch cmd and addr, then go to WDATA if W/R̄ = 1, otherwise to RFETCH.
  - **WDATA**: shift 16 bits. On the 16th rise:
    - drive `mem_write_data`;
    - pulse the selected write strobe for exactly 1 `clk` cycle;
    - one cycle later, increment the address.
    - Remain in WDATA.
  - **RFETCH**: present the address, wait `RD_LAT` cycles, load the 16-bit read data into the shift register, then go to RDATA.
  - **RDATA**: `miso` = shift-register MSB; shift on each `sck` fall. On the 16th rise, increment the address and go to RFETCH.
- Address wrap: the instruction address wraps 0x1FFF→0x0000; the data address wraps 0xFF→0x00.
- Abort: `cs_n` (synchronised) rising in any state → IDLE next cycle. Any partial word is discarded, no strobe is issued, and the address register keeps its value.
- Processor running: `start` = 1 forces IDLE and suppresses both strobes, including one due in the same cycle. `start` rising mid-frame behaves as an abort.
- The other memory's strobe stays 0. The address output of the memory not selected holds its last value.

## Timing
- Reset values: state = IDLE, `miso` = 0, both strobes = 0, both addresses = 0, `mem_write_data` = 0, `busy` = 0.
- Clock ratio: `clk` must be ≥ 8× the `sck` frequency.
- Input latency: `sck`/`cs_n`/`mosi` edges are seen 2–3 `clk` cycles after the pin changes.
- Write strobe latency: the strobe asserts 1 cycle after the 16th data rise is detected. `mem_write_data` and the address are stable in the strobe cycle.
- Read timing:
  - The first `miso` bit of each word must be valid before the first `sck` rise of that word.
  - RFETCH completes within `RD_LAT` + 1 cycles, which is guaranteed to fit in the half-`sck` period given the 8× ratio.
- `miso` outside RDATA is 0.

## Configuration
- `SPI_LOADER_READBACK_EN`:
  - **Defined**: read frames operate as described (RFETCH/RDATA).
  - **Undefined**: read frames go from HDR to a sink state that ignores all data until `cs_n` rises. `miso` is tied to 0, the `instr`/`data_read_data` inputs are unused, and no read logic is synthesised.

## Test plan
- **Reset**: assert `reset` low mid-WDATA → all outputs return to their reset values immediately; `busy` = 0.
- **Instruction write burst**: header 0xC0,0x10 then words 0x2004, 0xABCD → `instrw_en` pulses at `instr_mem_addr` 0x0010 with data 0x2004, then at 0x0011 with data 0xABCD; `dataw_en` stays 0.
- **Data address wrap**: header 0x80,0xFF then 2 words → `dataw_en` at `data_mem_addr` 0xFF, then at 0x00.
- **Readback** (`SPI_LOADER_READBACK_EN` defined): instruction memory holds 0x1234 at 0x0005 and 0x5678 at 0x0006; header 0x40,0x05, 32 clocks → `miso` stream 0x1234, 0x5678. With the macro undefined → `miso` = 0 throughout.
- **Abort**: raise `cs_n` after 9 data bits of a write word → no strobe; a new frame then starts cleanly in HDR.
- **Start gating**: `start` = 1 during a full write frame → no strobes, `busy` = 0.
